mips_multicycle_controller: RTL

- Next-generation control unit for the MIPS core: a multi-cycle FSM replacing the single-cycle opcode/ALU/PC-source decode.
- Sequences each instruction through fetch, decode, execute, memory and writeback states over 3–5 cycles.
- Stalls on a memory ready handshake.
- Drives a shared-memory, shared-ALU datapath (IR, MDR, A/B, ALUOut registers).

---
 rtl/mips_multicycle_controller_if.sv | 43 ++++
 rtl/mips_multicycle_controller.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_controller_if.sv
// Control/status bundle between the multi-cycle MIPS controller (master) and
// its datapath (slave): IR fields and memory handshake in, datapath controls out.
interface mips_multicycle_controller_if #(
    parameter int OPC_W   = 6,
    parameter int FUNC_W  = 6,
    parameter int ALUOP_W = 3,
    parameter int STATE_W = 4
);
    logic               zero;
    logic [OPC_W-1:0]   OPC;
    logic [FUNC_W-1:0]  func;
    logic               mem_ready;

    logic               PCWrite;
    logic               IorD;
    logic               IRWrite;
    logic               Mem_Read;
    logic               Mem_Write;
    logic               RegWrite;
    logic               ALUsrcA;
    logic [1:0]         ALUsrcB;
    logic [1:0]         RegDst;
    logic [1:0]         MemtoReg;
    logic [1:0]         PCsrc;
    logic [ALUOP_W-1:0] ALUoperation;
    logic               instr_done;
    logic               illegal_op;
    logic [STATE_W-1:0] state_o;

    modport master (
        input  zero, OPC, func, mem_ready,
        output PCWrite, IorD, IRWrite, Mem_Read, Mem_Write, RegWrite, ALUsrcA,
               ALUsrcB, RegDst, MemtoReg, PCsrc, ALUoperation, instr_done,
               illegal_op, state_o
    );

    modport slave (
        output zero, OPC, func, mem_ready,
        input  PCWrite, IorD, IRWrite, Mem_Read, Mem_Write, RegWrite, ALUsrcA,
               ALUsrcB, RegDst, MemtoReg, PCsrc, ALUoperation, instr_done,
               illegal_op, state_o
    );
endinterface

// File: rtl/mips_multicycle_controller.sv
// Multi-cycle MIPS control FSM (fetch/decode/execute/memory/writeback).
// Optional jal/jr support is built when MIPS_CTRL_JAL_JR_EN is defined.
module mips_multicycle_controller #(
    parameter int OPC_W   = 6,
    parameter int FUNC_W  = 6,
    parameter int ALUOP_W = 3,
    parameter int STATE_W = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    mips_multicycle_controller_if.master  bus
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RTWB   = 4'd7,
        S_BRANCH = 4'd8,
        S_IMMEX  = 4'd9,
        S_IMMWB  = 4'd10,
        S_JUMP   = 4'd11
`ifdef MIPS_CTRL_JAL_JR_EN
        ,
        S_JAL    = 4'd12,
        S_JR     = 4'd13
`endif
    } state_t;

    localparam logic [OPC_W-1:0] OP_RTYPE = OPC_W'(6'b000000);
    localparam logic [OPC_W-1:0] OP_LW    = OPC_W'(6'b100011);
    localparam logic [OPC_W-1:0] OP_SW    = OPC_W'(6'b101011);
    localparam logic [OPC_W-1:0] OP_BEQ   = OPC_W'(6'b000100);
    localparam logic [OPC_W-1:0] OP_BNE   = OPC_W'(6'b000101);
    localparam logic [OPC_W-1:0] OP_ADDI  = OPC_W'(6'b001000);
    localparam logic [OPC_W-1:0] OP_ANDI  = OPC_W'(6'b001100);
    localparam logic [OPC_W-1:0] OP_ORI   = OPC_W'(6'b001101);
    localparam logic [OPC_W-1:0] OP_SLTI  = OPC_W'(6'b001010);
    localparam logic [OPC_W-1:0] OP_J     = OPC_W'(6'b000010);
`ifdef MIPS_CTRL_JAL_JR_EN
    localparam logic [OPC_W-1:0]  OP_JAL  = OPC_W'(6'b000011);
    localparam logic [FUNC_W-1:0] FN_JR   = FUNC_W'(6'b001000);
`endif

    localparam logic [FUNC_W-1:0] FN_ADD = FUNC_W'(6'b100000);
    localparam logic [FUNC_W-1:0] FN_SUB = FUNC_W'(6'b100010);
    localparam logic [FUNC_W-1:0] FN_AND = FUNC_W'(6'b100100);
    localparam logic [FUNC_W-1:0] FN_OR  = FUNC_W'(6'b100101);
    localparam logic [FUNC_W-1:0] FN_SLT = FUNC_W'(6'b101010);

    localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(3'b010);
    localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(3'b110);
    localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(3'b000);
    localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(3'b001);
    localparam logic [ALUOP_W-1:0] ALU_SLT = ALUOP_W'(3'b111);

    state_t               r_state;
    state_t               w_state_next;

    logic                 w_pcwrite;
    logic                 w_iord;
    logic                 w_irwrite;
    logic                 w_mem_read;
    logic                 w_mem_write;
    logic                 w_regwrite;
    logic                 w_alusrca;
    logic [1:0]           w_alusrcb;
    logic [1:0]           w_regdst;
    logic [1:0]           w_memtoreg;
    logic [1:0]           w_pcsrc;
    logic [ALUOP_W-1:0]   w_aluop;
    logic                 w_instr_done;
    logic                 w_illegal_op;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = S_FETCH;
        w_pcwrite    = 1'b0;
        w_iord       = 1'b0;
        w_irwrite    = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_regwrite   = 1'b0;
        w_alusrca    = 1'b0;
        w_alusrcb    = 2'b00;
        w_regdst     = 2'b00;
        w_memtoreg   = 2'b00;
        w_pcsrc      = 2'b00;
        w_aluop      = ALU_AND;
        w_instr_done = 1'b0;
        w_illegal_op = 1'b0;

        case (r_state)
            S_FETCH: begin
                w_mem_read   = 1'b1;
                w_alusrcb    = 2'b01;
                w_aluop      = ALU_ADD;
                w_irwrite    = bus.mem_ready;
                w_pcwrite    = bus.mem_ready;
                w_state_next = bus.mem_ready ? S_DECODE : S_FETCH;
            end

            S_DECODE: begin
                // Precompute the branch target into ALUOut while dispatching.
                w_alusrcb = 2'b11;
                w_aluop   = ALU_ADD;
                case (bus.OPC)
                    OP_RTYPE: begin
`ifdef MIPS_CTRL_JAL_JR_EN
                        w_state_next = (bus.func == FN_JR) ? S_JR : S_EXEC;
`else
                        w_state_next = S_EXEC;
`endif
                    end
                    OP_LW, OP_SW:                      w_state_next = S_MEMADR;
                    OP_BEQ, OP_BNE:                    w_state_next = S_BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: w_state_next = S_IMMEX;
                    OP_J:                              w_state_next = S_JUMP;
`ifdef MIPS_CTRL_JAL_JR_EN
                    OP_JAL:                            w_state_next = S_JAL;
`endif
                    default: begin
                        w_illegal_op = 1'b1;
                        w_state_next = S_FETCH;
                    end
                endcase
            end

            S_MEMADR: begin
                w_alusrca    = 1'b1;
                w_alusrcb    = 2'b10;
                w_aluop      = ALU_ADD;
                w_state_next = (bus.OPC == OP_SW) ? S_MEMWR : S_MEMRD;
            end

            S_MEMRD: begin
                w_mem_read   = 1'b1;
                w_iord       = 1'b1;
                w_state_next = bus.mem_ready ? S_MEMWB : S_MEMRD;
            end

            S_MEMWB: begin
                w_regwrite   = 1'b1;
                w_regdst     = 2'b00;
                w_memtoreg   = 2'b01;
                w_instr_done = 1'b1;
                w_state_next = S_FETCH;
            end

            S_MEMWR: begin
                w_mem_write  = 1'b1;
                w_iord       = 1'b1;
                w_instr_done = bus.mem_ready;
                w_state_next = bus.mem_ready ? S_FETCH : S_MEMWR;
            end

            S_EXEC: begin
                w_alusrca    = 1'b1;
                w_alusrcb    = 2'b00;
                w_state_next = S_RTWB;
                case (bus.func)
                    FN_ADD:  w_aluop = ALU_ADD;
                    FN_SUB:  w_aluop = ALU_SUB;
                    FN_AND:  w_aluop = ALU_AND;
                    FN_OR:   w_aluop = ALU_OR;
                    FN_SLT:  w_aluop = ALU_SLT;
                    default: begin
                        w_aluop      = ALU_ADD;
                        w_illegal_op = 1'b1;
                        w_state_next = S_FETCH;
                    end
                endcase
            end

            S_RTWB: begin
                w_regwrite   = 1'b1;
                w_regdst     = 2'b01;
                w_memtoreg   = 2'b00;
                w_instr_done = 1'b1;
                w_state_next = S_FETCH;
            end

            S_BRANCH: begin
                // IR is stable after fetch, so OPC still tells beq from bne here.
                w_alusrca    = 1'b1;
                w_alusrcb    = 2'b00;
                w_aluop      = ALU_SUB;
                w_pcsrc      = 2'b01;
                w_instr_done = 1'b1;
                w_pcwrite    = (bus.OPC == OP_BNE) ? ~bus.zero : bus.zero;
                w_state_next = S_FETCH;
            end

            S_IMMEX: begin
                w_alusrca    = 1'b1;
                w_alusrcb    = 2'b10;
                w_state_next = S_IMMWB;
                case (bus.OPC)
                    OP_ANDI: w_aluop = ALU_AND;
                    OP_ORI:  w_aluop = ALU_OR;
                    OP_SLTI: w_aluop = ALU_SLT;
                    default: w_aluop = ALU_ADD;
                endcase
            end

            S_IMMWB: begin
                w_regwrite   = 1'b1;
                w_regdst     = 2'b00;
                w_memtoreg   = 2'b00;
                w_instr_done = 1'b1;
                w_state_next = S_FETCH;
            end

            S_JUMP: begin
                w_pcwrite    = 1'b1;
                w_pcsrc      = 2'b10;
                w_instr_done = 1'b1;
                w_state_next = S_FETCH;
            end

`ifdef MIPS_CTRL_JAL_JR_EN
            S_JAL: begin
                w_regwrite   = 1'b1;
                w_regdst     = 2'b10;
                w_memtoreg   = 2'b10;
                w_pcwrite    = 1'b1;
                w_pcsrc      = 2'b10;
                w_instr_done = 1'b1;
                w_state_next = S_FETCH;
            end

            S_JR: begin
                w_pcwrite    = 1'b1;
                w_pcsrc      = 2'b11;
                w_instr_done = 1'b1;
                w_state_next = S_FETCH;
            end
`endif

            default: w_state_next = S_FETCH;
        endcase

        // Reset gates every control so an aborted instruction cannot write anything.
        if (!rst) begin
            w_pcwrite    = 1'b0;
            w_iord       = 1'b0;
            w_irwrite    = 1'b0;
            w_mem_read   = 1'b0;
            w_mem_write  = 1'b0;
            w_regwrite   = 1'b0;
            w_alusrca    = 1'b0;
            w_alusrcb    = 2'b00;
            w_regdst     = 2'b00;
            w_memtoreg   = 2'b00;
            w_pcsrc      = 2'b00;
            w_aluop      = '0;
            w_instr_done = 1'b0;
            w_illegal_op = 1'b0;
        end
    end

    assign bus.PCWrite      = w_pcwrite;
    assign bus.IorD         = w_iord;
    assign bus.IRWrite      = w_irwrite;
    assign bus.Mem_Read     = w_mem_read;
    assign bus.Mem_Write    = w_mem_write;
    assign bus.RegWrite     = w_regwrite;
    assign bus.ALUsrcA      = w_alusrca;
    assign bus.ALUsrcB      = w_alusrcb;
    assign bus.RegDst       = w_regdst;
    assign bus.MemtoReg     = w_memtoreg;
    assign bus.PCsrc        = w_pcsrc;
    assign bus.ALUoperation = w_aluop;
    assign bus.instr_done   = w_instr_done;
    assign bus.illegal_op   = w_illegal_op;
    assign bus.state_o      = rst ? STATE_W'(r_state) : '0;

endmodule
